pwm_deadtime_core: RTL and testbench
====================================

# pwm_deadtime_core

Dead-time and complementary-output stage sitting directly downstream of the PWM core's `pwm_out` vector. Each of W PWM channels becomes a high-side/low-side pair for half-bridge drivers. Both sides are never active together, and every switch-over inserts a programmable dead interval with both sides inactive. The block is configured over the standard 5-bit-address MMIO slot interface.

## Interface
- `W`, 8, number of channels; matches the upstream PWM core width.
- `DW`, 8, dead-time counter width in bits; maximum dead time is 2^DW−1 clocks.
- `clk`  in  1  system clock. The block has one clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cs`  in  1  slot select.
- `read`  in  1  read strobe.
- `write`  in  1  write strobe.
- `addr`  in  5  register address.
- `wr_data`  in  32  write data.
- `rd_data`  out  32  read data, combinational from `addr`.
- `pwm_in`  in  W  PWM outputs from the upstream core, synchronous to `clk`.
- `hi_out`  out  W  high-side drive, registered.
- `lo_out`  out  W  low-side drive, registered.

## Operation
- Register map, selected by `addr`:
  - 0x00 DT: `wr_data[DW-1:0]`.
  - 0x01 EN: `wr_data[W-1:0]`, per-channel enable.
  - 0x02 POL: `wr_data[W-1:0]`. A POL bit of 1 makes both outputs of that channel active-low.
  - 0x03 STATUS: read-only.
- Writes take effect on the edge where `cs && write` is high. Reads return zero-extended DT, EN or POL. STATUS = {W bits "in dead interval", W bits "pwm_in"}. All other addresses read 0.
- Reset values: DT=0, EN=0, POL=0, all channels in OFF, `hi_out`=`lo_out`=0.
- Per-channel FSM with states OFF, HI_ON, DEAD_TO_LO, LO_ON, DEAD_TO_HI, plus a DW-bit down-counter `cnt`:
  - OFF: both sides inactive. When EN=1, go to DEAD_TO_HI if `pwm_in`=1, else DEAD_TO_LO. Load `cnt` = DT.
  - HI_ON: if `pwm_in`=0, go to DEAD_TO_LO and load `cnt` = DT.
  - LO_ON: if `pwm_in`=1, go to DEAD_TO_HI and load `cnt` = DT.
  - DEAD_x: both sides inactive. While `cnt`>1, decrement. At `cnt`≤1, go to HI_ON if the current `pwm_in`=1, else LO_ON. The target is re-evaluated at expiry; an input that toggles back mid-dead never shortens the dead interval.
  - DT=0: no dead state is entered. HI_ON↔LO_ON switch on a single edge. OFF goes directly to the ON state matching `pwm_in`.
  - From any state, EN=0 forces OFF on the next edge. This pre-empts everything else.
- Active output levels: `hi_out` = (state==HI_ON) XOR POL, `lo_out` = (state==LO_ON) XOR POL.
- Invariant: `hi_out` and `lo_out` are never both at the active level in any cycle.
- Changing DT mid-operation does not affect a running count; the new value applies at the next load. Changing POL flips the levels on the next edge without a state change.
- `pwm_in` is already in the `clk` domain; no synchronizer is used.

## Timing
- Outputs are registered and decoded from the next state. A `pwm_in` change sampled at edge k shows on the outputs at edge k.
- Active side goes inactive at edge k. The opposite side goes active at edge k+DT.
- The both-inactive window is exactly DT clock periods (DT ≥ 1).
- Enable latency: EN written at edge k gives the first active output at edge k+1+DT.
- Disable latency: EN cleared at edge k forces both outputs inactive at edge k+1.
- Asynchronous `reset_n` assertion forces OFF and outputs 0 immediately, including mid-dead. Release is synchronous to `clk`.

## Structure
- Package `pwm_dt_pkg` holds the state enum `dt_state_t` (OFF, HI_ON, DEAD_TO_LO, LO_ON, DEAD_TO_HI) and the address constants `DT_ADDR`=0, `EN_ADDR`=1, `POL_ADDR`=2, `STAT_ADDR`=3.
- Sub-module `pwm_dt_channel`, parameterized by DW, contains:
  - the FSM and counter;
  - output registers with polarity applied;
  - a `dead` status flag.
- The top level holds the register file and read mux, and instantiates W channels with a generate loop.

## Test plan
- **Reset:** assert `reset_n`=0 mid-run with DT=5 → `hi_out`=`lo_out`=0 immediately; all registers read back 0.
- **Basic dead time:** DT=3, EN=0x01, `pwm_in[0]` rises at edge k → `lo_out[0]`=0 at k, `hi_out[0]`=1 at k+3. Falling edge is symmetric.
- **Glitch during dead:** DT=4, `pwm_in[0]` pulses low for 2 cycles while HI_ON → 4 cycles with both inactive, then HI_ON. The low side is never active.
- **DT=0 and POL:** DT=0, POL=0x01 → `hi_out[0]`/`lo_out[0]` swap on the same edge as `pwm_in` changes; inactive level is 1.
- **Enable/disable:** EN written 0x03 at edge k with DT=2 → first active outputs at k+3. Clearing EN mid-dead gives OFF at the next edge.
- **Random W=8 run, 10k cycles:** a per-cycle assertion checks that no channel is ever active on both sides. STATUS readback matches `pwm_in` and the dead flags.

Source files
------------

// File: rtl/pwm_dt_pkg.sv
// Shared state encoding and register addresses for the dead-time output stage.
package pwm_dt_pkg;

    typedef enum logic [2:0] {
        OFF,
        HI_ON,
        DEAD_TO_LO,
        LO_ON,
        DEAD_TO_HI
    } dt_state_t;

    localparam logic [4:0] DT_ADDR   = 5'd0;
    localparam logic [4:0] EN_ADDR   = 5'd1;
    localparam logic [4:0] POL_ADDR  = 5'd2;
    localparam logic [4:0] STAT_ADDR = 5'd3;

endpackage

// File: rtl/pwm_dt_channel.sv
// One half-bridge channel: turns a PWM level into a complementary hi/lo pair
// with a dead interval of dt clocks inserted at every switch-over.
module pwm_dt_channel
    import pwm_dt_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          pol,
    input  logic [DW-1:0] dt,
    input  logic          pwm_in,
    output logic          hi_out,
    output logic          lo_out,
    output logic          dead
);

    dt_state_t     state_reg, state_next;
    logic [DW-1:0] cnt_reg, cnt_next;
    logic          hi_reg, lo_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (!en) begin
            state_next = OFF;
        end else begin
            case (state_reg)
                OFF: begin
                    if (dt == '0) begin
                        state_next = pwm_in ? HI_ON : LO_ON;
                    end else begin
                        state_next = pwm_in ? DEAD_TO_HI : DEAD_TO_LO;
                        cnt_next   = dt;
                    end
                end
                HI_ON: begin
                    if (!pwm_in) begin
                        state_next = (dt == '0) ? LO_ON : DEAD_TO_LO;
                        cnt_next   = dt;
                    end
                end
                LO_ON: begin
                    if (pwm_in) begin
                        state_next = (dt == '0) ? HI_ON : DEAD_TO_HI;
                        cnt_next   = dt;
                    end
                end
                DEAD_TO_LO, DEAD_TO_HI: begin
                    // Target side is chosen at expiry; a mid-dead toggle never shortens the wait.
                    if (cnt_reg > DW'(1)) begin
                        cnt_next = cnt_reg - DW'(1);
                    end else begin
                        state_next = pwm_in ? HI_ON : LO_ON;
                    end
                end
                default: state_next = OFF;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= OFF;
            cnt_reg   <= '0;
            hi_reg    <= 1'b0;
            lo_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            hi_reg    <= (state_next == HI_ON) ^ pol;
            lo_reg    <= (state_next == LO_ON) ^ pol;
        end
    end

    assign hi_out = hi_reg;
    assign lo_out = lo_reg;
    assign dead   = (state_reg == DEAD_TO_LO) || (state_reg == DEAD_TO_HI);

endmodule

// File: rtl/pwm_deadtime_core.sv
// Dead-time / complementary-output stage: MMIO register file plus W
// independent half-bridge channels.
module pwm_deadtime_core
    import pwm_dt_pkg::*;
#(
    parameter int W  = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    input  logic [W-1:0]  pwm_in,
    output logic [W-1:0]  hi_out,
    output logic [W-1:0]  lo_out
);

    logic [DW-1:0] dt_reg;
    logic [W-1:0]  en_reg;
    logic [W-1:0]  pol_reg;
    logic [W-1:0]  dead_vec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dt_reg  <= '0;
            en_reg  <= '0;
            pol_reg <= '0;
        end else if (cs && write) begin
            case (addr)
                DT_ADDR:  dt_reg  <= wr_data[DW-1:0];
                EN_ADDR:  en_reg  <= wr_data[W-1:0];
                POL_ADDR: pol_reg <= wr_data[W-1:0];
                default: ;
            endcase
        end
    end

    // Read data is a pure function of addr; the read strobe carries no side effect.
    always_comb begin
        rd_data = '0;
        case (addr)
            DT_ADDR:   rd_data = 32'(dt_reg);
            EN_ADDR:   rd_data = 32'(en_reg);
            POL_ADDR:  rd_data = 32'(pol_reg);
            STAT_ADDR: rd_data = 32'({dead_vec, pwm_in});
            default:   rd_data = '0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{read, wr_data};

    for (genvar gi = 0; gi < W; gi++) begin : g_ch
        pwm_dt_channel #(
            .DW(DW)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en_reg[gi]),
            .pol     (pol_reg[gi]),
            .dt      (dt_reg),
            .pwm_in  (pwm_in[gi]),
            .hi_out  (hi_out[gi]),
            .lo_out  (lo_out[gi]),
            .dead    (dead_vec[gi])
        );
    end

endmodule

// File: tb/tb_pwm_deadtime_core.sv
// Self-checking bench for pwm_deadtime_core: vector table with a scoreboard
// queue, hand-written reset/readback sequences and a randomised property run.
module tb_pwm_deadtime_core;
    import pwm_dt_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs, read, write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [7:0]  pwm_in;
    logic [7:0]  hi_out, lo_out;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [7:0]  pwm;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    pwm_deadtime_core #(.W(8), .DW(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .pwm_in  (pwm_in),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        step();
        cs = 1'b0; write = 1'b0;
        $display("wr   addr=%0d data=0x%08h", a, d);
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        addr = a; read = 1'b1;
        #1;
        check(name, rd_data, exp);
        $display("rd   addr=%0d data=0x%08h", a, rd_data);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic vec_t rw(input logic [4:0] a, input logic [31:0] d,
                                input logic [7:0] p, input logic [7:0] h, input logic [7:0] l);
        vec_t v;
        v.wr = 1'b1; v.addr = a; v.data = d; v.pwm = p; v.hi = h; v.lo = l;
        return v;
    endfunction

    function automatic vec_t r(input logic [7:0] p, input logic [7:0] h, input logic [7:0] l);
        vec_t v;
        v.wr = 1'b0; v.addr = 5'd0; v.data = 32'd0; v.pwm = p; v.hi = h; v.lo = l;
        return v;
    endfunction

    // Property-based run with EN=0xFF: no double-active side, each side follows
    // pwm_in, every both-inactive gap is exactly dt, STATUS mirrors the outputs.
    task automatic run_seg(input logic [7:0] dt, input logic [7:0] pol, input int cycles);
        int         run [8];
        logic [1:0] side[8];
        logic [1:0] cur;
        logic [7:0] hi_act, lo_act;
        wr(EN_ADDR, 32'h0);
        wr(DT_ADDR, 32'(dt));
        wr(POL_ADDR, 32'(pol));
        wr(EN_ADDR, 32'hFF);
        for (int i = 0; i < 8; i++) begin
            run[i]  = 0;
            side[i] = 2'd0;
        end
        addr = STAT_ADDR; read = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            pwm_in = pwm_in ^ 8'($urandom & $urandom);
            step();
            hi_act = hi_out ^ pol;
            lo_act = lo_out ^ pol;
            check("both_active", 32'(hi_act & lo_act), 32'h0);
            check("hi_tracks_pwm", 32'(hi_act & ~pwm_in), 32'h0);
            check("lo_tracks_pwm", 32'(lo_act & pwm_in), 32'h0);
            check("status", rd_data, {16'h0, ~(hi_act | lo_act), pwm_in});
            for (int i = 0; i < 8; i++) begin
                cur = hi_act[i] ? 2'd1 : (lo_act[i] ? 2'd2 : 2'd0);
                if (cur != 2'd0) begin
                    if (cur != side[i] || run[i] != 0)
                        check($sformatf("dead_window_ch%0d", i), 32'(run[i]), 32'(dt));
                    run[i]  = 0;
                    side[i] = cur;
                end else begin
                    run[i]++;
                end
            end
        end
        $display("seg  dt=%0d pol=0x%02h cycles=%0d done", dt, pol, cycles);
    endtask

    initial begin
        vec_t v;
        exp_t e;

        reset_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = 5'd0; wr_data = 32'd0; pwm_in = 8'h00;

        // Reset state
        step();
        step();
        check("reset_hi", 32'(hi_out), 32'h0);
        check("reset_lo", 32'(lo_out), 32'h0);
        rd_check("reset_dt", DT_ADDR, 32'h0);
        rd_check("reset_en", EN_ADDR, 32'h0);
        rd_check("reset_pol", POL_ADDR, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("idle_hi", 32'(hi_out), 32'h0);
        check("idle_lo", 32'(lo_out), 32'h0);

        // Register readback with upper write bits set
        wr(DT_ADDR, 32'hFFFF_FFA5);
        wr(EN_ADDR, 32'hFFFF_FF3C);
        wr(POL_ADDR, 32'h0000_0081);
        rd_check("rb_dt", DT_ADDR, 32'h0000_00A5);
        rd_check("rb_en", EN_ADDR, 32'h0000_003C);
        rd_check("rb_pol", POL_ADDR, 32'h0000_0081);
        rd_check("rb_status", STAT_ADDR, 32'h0000_3C00);
        rd_check("rb_addr4", 5'd4, 32'h0);
        rd_check("rb_addr31", 5'd31, 32'h0);

        // Asynchronous reset in the middle of a dead interval
        do_reset();
        pwm_in = 8'h0F;
        wr(DT_ADDR, 32'd5);
        wr(POL_ADDR, 32'hFF);
        wr(EN_ADDR, 32'hFF);
        step();
        step();
        check("pre_reset_hi", 32'(hi_out), 32'hFF);
        check("pre_reset_lo", 32'(lo_out), 32'hFF);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_hi", 32'(hi_out), 32'h0);
        check("async_reset_lo", 32'(lo_out), 32'h0);
        rd_check("async_reset_dt", DT_ADDR, 32'h0);
        rd_check("async_reset_en", EN_ADDR, 32'h0);
        rd_check("async_reset_pol", POL_ADDR, 32'h0);
        rd_check("async_reset_status", STAT_ADDR, 32'h0000_000F);
        @(negedge clk);
        reset_n = 1'b1;
        pwm_in = 8'h00;

        // Per-edge vector table: {write?, addr, data, pwm_in, expected hi, expected lo}
        vecs.push_back(rw(DT_ADDR, 32'd3, 8'h00, 8'h00, 8'h00));
        vecs.push_back(rw(EN_ADDR, 32'd1, 8'h00, 8'h00, 8'h00));
        repeat (3) vecs.push_back(r(8'h00, 8'h00, 8'h00));
        vecs.push_back(r(8'h00, 8'h00, 8'h01));
        repeat (3) vecs.push_back(r(8'h01, 8'h00, 8'h00));
        repeat (2) vecs.push_back(r(8'h01, 8'h01, 8'h00));
        repeat (3) vecs.push_back(r(8'h00, 8'h00, 8'h00));
        vecs.push_back(r(8'h00, 8'h00, 8'h01));
        vecs.push_back(rw(DT_ADDR, 32'd4, 8'h00, 8'h00, 8'h01));
        repeat (4) vecs.push_back(r(8'h01, 8'h00, 8'h00));
        repeat (2) vecs.push_back(r(8'h01, 8'h01, 8'h00));
        // two-cycle low glitch while HI_ON: full 4-cycle dead, back to HI
        repeat (2) vecs.push_back(r(8'h00, 8'h00, 8'h00));
        repeat (2) vecs.push_back(r(8'h01, 8'h00, 8'h00));
        vecs.push_back(r(8'h01, 8'h01, 8'h00));
        // DT rewritten on the load edge: running count keeps the old value
        vecs.push_back(rw(DT_ADDR, 32'd1, 8'h00, 8'h00, 8'h00));
        repeat (3) vecs.push_back(r(8'h00, 8'h00, 8'h00));
        vecs.push_back(r(8'h00, 8'h00, 8'h01));
        vecs.push_back(r(8'h01, 8'h00, 8'h00));
        vecs.push_back(r(8'h01, 8'h01, 8'h00));
        // DT=0 with inverted polarity
        vecs.push_back(rw(DT_ADDR, 32'd0, 8'h01, 8'h01, 8'h00));
        vecs.push_back(rw(POL_ADDR, 32'd1, 8'h01, 8'h01, 8'h00));
        vecs.push_back(r(8'h01, 8'h00, 8'h01));
        vecs.push_back(r(8'h00, 8'h01, 8'h00));
        vecs.push_back(r(8'h01, 8'h00, 8'h01));
        vecs.push_back(r(8'h00, 8'h01, 8'h00));
        vecs.push_back(rw(POL_ADDR, 32'd0, 8'h00, 8'h01, 8'h00));
        vecs.push_back(r(8'h00, 8'h00, 8'h01));
        // Enable latency with DT=2, then disable pre-empting a dead expiry
        vecs.push_back(rw(DT_ADDR, 32'd2, 8'h00, 8'h00, 8'h01));
        vecs.push_back(rw(EN_ADDR, 32'd3, 8'h02, 8'h00, 8'h01));
        repeat (2) vecs.push_back(r(8'h02, 8'h00, 8'h01));
        vecs.push_back(r(8'h02, 8'h02, 8'h01));
        vecs.push_back(r(8'h03, 8'h02, 8'h00));
        vecs.push_back(rw(EN_ADDR, 32'd0, 8'h03, 8'h02, 8'h00));
        repeat (2) vecs.push_back(r(8'h03, 8'h00, 8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            cs = v.wr; write = v.wr; addr = v.addr; wr_data = v.data; pwm_in = v.pwm;
            e.hi = v.hi;
            e.lo = v.lo;
            exp_q.push_back(e);
            step();
            e = exp_q.pop_front();
            check($sformatf("row%0d_hi", i), 32'(hi_out), 32'(e.hi));
            check($sformatf("row%0d_lo", i), 32'(lo_out), 32'(e.lo));
            $display("row  %0d pwm=0x%02h hi=0x%02h lo=0x%02h", i, v.pwm, hi_out, lo_out);
        end
        cs = 1'b0; write = 1'b0;

        // Randomised run across several dead times and polarities
        do_reset();
        pwm_in = 8'h00;
        run_seg(8'd1, 8'($urandom_range(0, 255)), 2500);
        run_seg(8'd2, 8'($urandom_range(0, 255)), 2500);
        run_seg(8'd3, 8'($urandom_range(0, 255)), 2500);
        run_seg(8'd7, 8'($urandom_range(0, 255)), 2500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
